fpu_align_add: RTL and testbench
================================

# fpu_align_add

Multi-cycle alignment and add/subtract stage of the FPU adder path. It accepts two packed floating-point operands over a valid/ready handshake. It swaps them so the larger magnitude comes first, then right-shifts the smaller mantissa one bit per cycle until the exponents match. It adds or subtracts the aligned mantissas and presents an unnormalized {carry, hidden, fraction} mantissa plus exponent, which feeds `fpu_normalizer` directly downstream.

## Interface
- `Mantissa_Size`, 23: fraction width M.
- `Exponent_Size`, 8: exponent width E.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: high only in IDLE.
- `a` in 1+E+M: operand A, packed {sign, exponent, fraction}.
- `b` in 1+E+M: operand B, same packing.
- `sub` in 1: 1 = compute a−b (B sign inverted at capture).
- `out_valid` out 1: result valid, high only in DONE.
- `out_ready` in 1: downstream accepts result.
- `out_mantissa` out M+2: bit M+1 carry, bit M hidden, [M-1:0] fraction; normalizer input format.
- `out_exponent` out E: larger operand exponent.
- `out_sign` out 1: result sign.
- `out_sticky` out 1: any nonzero bit lost in alignment (see Configuration).

## Operation
- FSM states: IDLE, ALIGN, ADD, DONE.
- Hidden bit is 1 when the exponent is nonzero and 0 when it is zero; zero/denormals carry no implicit one.
- Inf/NaN get no special handling here; downstream special-case logic handles them.
- IDLE: when `in_valid` is high at the edge, capture both operands.
  - Order by exponent, then by mantissa, so that |A| ≥ |B|; on equality, keep `a` as A.
  - Load diff = expA − expB, unsigned E bits.
  - Next state: ALIGN.
- ALIGN, evaluated each edge:
  - If diff ≥ M+2: B mantissa → 0 (flush); go to ADD.
  - Else if diff == 0: go to ADD.
  - Else: B mantissa >>= 1 and diff −= 1; stay in ALIGN.
- ADD, one edge:
  - Equal signs: out_mantissa = A + B, carry lands in bit M+1.
  - Opposite signs: out_mantissa = A − B, never negative because of the swap.
  - out_sign = sign of A, except that an exact-zero result forces out_sign = 0.
  - out_exponent = expA.
  - Next state: DONE.
- DONE:
  - `out_valid` = 1; all outputs are held stable.
  - When `out_ready` is high at the edge, go to IDLE.
  - No new operand is taken the same cycle (no overlap).
- Reset (any time, including mid-ALIGN):
  - State → IDLE.
  - `out_valid`=0, `in_ready`=1.
  - `out_mantissa`, `out_exponent`, `out_sign`, `out_sticky` all 0.
  - The in-flight operation is discarded.

## Timing
- Latency: `out_valid` rises 2+d edges after the accepting edge, where d = exponent difference.
  - Applies for d ≤ M+1.
  - For d ≥ M+2 (flush), latency is exactly 2.
- Throughput: one operation per (latency + 1) cycles minimum, because DONE→IDLE costs one edge.
- `in_ready` is a combinational decode of state == IDLE.
- `out_valid` is a combinational decode of state == DONE.
- Outputs are registered and change only on the ADD edge or on reset.
- `in_valid` outside IDLE is ignored; the operands are not captured.
- `out_ready` outside DONE is ignored.

## Configuration
- Macro: `FPU_ALIGN_STICKY_EN`.
- Defined:
  - A sticky register clears at capture.
  - It ORs in every 1 bit shifted out of B in ALIGN.
  - It ORs in the entire B mantissa on flush.
  - `out_sticky` is latched at the ADD edge.
- Undefined: `out_sticky` is tied to 0 and the sticky register is not built.

## Test plan
- a=0x3F800000, b=0x3F800000, sub=0 → out_mantissa=0x1000000, out_exponent=0x7F, out_sign=0, out_valid 2 edges after accept.
- a=0x3FC00000, b=0x3F400000 (d=1) → out_mantissa=0x1200000, out_exponent=0x7F, latency 3.
- a=0x40000000, b=0x40000000, sub=1 → out_mantissa=0, out_exponent=0x80, out_sign=0.
- a=0x3F800000, b=0xC0800000 (swap, d=2) → out_mantissa=0x600000, out_exponent=0x81, out_sign=1, latency 4.
- a=0x4E800000, b=0x3F800000 (d=30, flush) → out_mantissa=0x800000, out_exponent=0x9D, latency 2; out_sticky=1 with macro defined, 0 without.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0 throughout.
  - Assert `rst_n`=0 mid-ALIGN → immediately `out_valid`=0, `in_ready`=1, out_mantissa=0.

Source files
------------

// File: rtl/fpu_align_add_if.sv
// ---------------------------------------------------------------------------
// fpu_align_add_if
// Handshake and data bundle for the fpu_align_add stage.
//   Input side  : in_valid, in_ready, a, b ({sign, exponent, fraction}), sub
//   Output side : out_valid, out_ready, out_mantissa ({carry, hidden, frac}),
//                 out_exponent, out_sign, out_sticky
// Modports:
//   master - the producer/consumer around the stage (drives operands and
//            out_ready, observes results)
//   slave  - the fpu_align_add stage itself
// ---------------------------------------------------------------------------
interface fpu_align_add_if #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [Exponent_Size+Mantissa_Size:0]   a;
    logic [Exponent_Size+Mantissa_Size:0]   b;
    logic                                   sub;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [Mantissa_Size+1:0]               out_mantissa;
    logic [Exponent_Size-1:0]               out_exponent;
    logic                                   out_sign;
    logic                                   out_sticky;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, out_mantissa, out_exponent, out_sign, out_sticky
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, out_mantissa, out_exponent, out_sign, out_sticky
    );
endinterface

// File: rtl/fpu_align_add.sv
// ---------------------------------------------------------------------------
// fpu_align_add
// Multi-cycle alignment and add/subtract stage of the FPU adder path.
// Operands are ordered so |A| >= |B|, B's mantissa is shifted right one bit
// per cycle until exponents match (or flushed when the gap is too large),
// then the aligned mantissas are added or subtracted. The unnormalized
// {carry, hidden, fraction} result feeds fpu_normalizer.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   io    - fpu_align_add_if.slave (operand handshake in, result handshake out)
//
// Optional feature macro: FPU_ALIGN_STICKY_EN
//   defined   : out_sticky reports any nonzero bit lost during alignment
//   undefined : out_sticky is tied to 0, no sticky storage is built
// ---------------------------------------------------------------------------
module fpu_align_add #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    fpu_align_add_if.slave  io
);
    localparam int M = Mantissa_Size;
    localparam int E = Exponent_Size;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

    state_t         state_q, state_d;
    logic           sign_a_q, sign_a_d;
    logic           sign_b_q, sign_b_d;
    logic [E-1:0]   exp_a_q, exp_a_d;
    logic [E-1:0]   diff_q, diff_d;
    logic [M:0]     mant_a_q, mant_a_d;     // {hidden, fraction}
    logic [M:0]     mant_b_q, mant_b_d;
    logic [M+1:0]   out_mant_q, out_mant_d;
    logic [E-1:0]   out_exp_q, out_exp_d;
    logic           out_sign_q, out_sign_d;

    // Operand field extraction at capture time
    logic           a_sign, b_sign;
    logic [E-1:0]   a_exp, b_exp;
    logic [M:0]     a_mant, b_mant;
    logic           swap;
    logic           flush;
    logic [M+1:0]   sum_add, sum_sub, result;

    assign a_sign = io.a[E+M];
    assign b_sign = io.b[E+M] ^ io.sub;
    assign a_exp  = io.a[E+M-1:M];
    assign b_exp  = io.b[E+M-1:M];
    // Zero/denormal exponents carry no implicit one
    assign a_mant = {|a_exp, io.a[M-1:0]};
    assign b_mant = {|b_exp, io.b[M-1:0]};
    // {exponent, fraction} compares as a plain unsigned magnitude, which
    // orders by exponent first and fraction second; ties keep a as A.
    assign swap   = io.b[E+M-1:0] > io.a[E+M-1:0];

    assign flush   = 32'(diff_q) >= 32'(M + 2);
    assign sum_add = {1'b0, mant_a_q} + {1'b0, mant_b_q};
    assign sum_sub = {1'b0, mant_a_q} - {1'b0, mant_b_q};
    assign result  = (sign_a_q == sign_b_q) ? sum_add : sum_sub;

`ifdef FPU_ALIGN_STICKY_EN
    logic sticky_q, sticky_d;
    logic out_sticky_q, out_sticky_d;
    assign io.out_sticky = out_sticky_q;
`else
    assign io.out_sticky = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        exp_a_d    = exp_a_q;
        diff_d     = diff_q;
        mant_a_d   = mant_a_q;
        mant_b_d   = mant_b_q;
        out_mant_d = out_mant_q;
        out_exp_d  = out_exp_q;
        out_sign_d = out_sign_q;
`ifdef FPU_ALIGN_STICKY_EN
        sticky_d     = sticky_q;
        out_sticky_d = out_sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    state_d = ALIGN;
                    if (swap) begin
                        sign_a_d = b_sign;
                        sign_b_d = a_sign;
                        exp_a_d  = b_exp;
                        mant_a_d = b_mant;
                        mant_b_d = a_mant;
                        diff_d   = b_exp - a_exp;
                    end else begin
                        sign_a_d = a_sign;
                        sign_b_d = b_sign;
                        exp_a_d  = a_exp;
                        mant_a_d = a_mant;
                        mant_b_d = b_mant;
                        diff_d   = a_exp - b_exp;
                    end
`ifdef FPU_ALIGN_STICKY_EN
                    sticky_d = 1'b0;
`endif
                end
            end
            ALIGN: begin
                if (flush) begin
                    mant_b_d = '0;
                    state_d  = ADD;
`ifdef FPU_ALIGN_STICKY_EN
                    sticky_d = sticky_q | (|mant_b_q);
`endif
                end else if (diff_q == '0) begin
                    state_d = ADD;
                end else begin
                    mant_b_d = mant_b_q >> 1;
                    diff_d   = diff_q - {{(E-1){1'b0}}, 1'b1};
`ifdef FPU_ALIGN_STICKY_EN
                    sticky_d = sticky_q | mant_b_q[0];
`endif
                end
            end
            ADD: begin
                out_mant_d = result;
                out_exp_d  = exp_a_q;
                // Exact cancellation yields +0 regardless of A's sign
                out_sign_d = (result == '0) ? 1'b0 : sign_a_q;
                state_d    = DONE;
`ifdef FPU_ALIGN_STICKY_EN
                out_sticky_d = sticky_q;
`endif
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            exp_a_q    <= '0;
            diff_q     <= '0;
            mant_a_q   <= '0;
            mant_b_q   <= '0;
            out_mant_q <= '0;
            out_exp_q  <= '0;
            out_sign_q <= 1'b0;
`ifdef FPU_ALIGN_STICKY_EN
            sticky_q     <= 1'b0;
            out_sticky_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            exp_a_q    <= exp_a_d;
            diff_q     <= diff_d;
            mant_a_q   <= mant_a_d;
            mant_b_q   <= mant_b_d;
            out_mant_q <= out_mant_d;
            out_exp_q  <= out_exp_d;
            out_sign_q <= out_sign_d;
`ifdef FPU_ALIGN_STICKY_EN
            sticky_q     <= sticky_d;
            out_sticky_q <= out_sticky_d;
`endif
        end
    end

    assign io.in_ready     = (state_q == IDLE);
    assign io.out_valid    = (state_q == DONE);
    assign io.out_mantissa = out_mant_q;
    assign io.out_exponent = out_exp_q;
    assign io.out_sign     = out_sign_q;
endmodule

// File: tb/tb_fpu_align_add.sv
// ---------------------------------------------------------------------------
// tb_fpu_align_add
// Directed testbench for fpu_align_add with hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_fpu_align_add;
    localparam int M = 23;
    localparam int E = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Last observed result
    logic [M+1:0] obs_mant;
    logic [E-1:0] obs_exp;
    logic         obs_sign;
    logic         obs_sticky;
    int           obs_lat;

    fpu_align_add_if #(.Mantissa_Size(M), .Exponent_Size(E)) bus ();

    fpu_align_add #(.Mantissa_Size(M), .Exponent_Size(E)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [24:0] mant;
        logic [7:0]  exp;
        logic        sign;
        int          lat;
        logic        sticky_en;   // expected sticky when the feature is built
    } vec_t;

    // Drive one operation and wait for out_valid; leaves the DUT in DONE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        obs_lat = 0;
        while (!bus.out_valid && obs_lat < 100) begin
            @(posedge clk);
            #1;
            obs_lat++;
        end
        obs_mant   = bus.out_mantissa;
        obs_exp    = bus.out_exponent;
        obs_sign   = bus.out_sign;
        obs_sticky = bus.out_sticky;
        $display("op a=%08h b=%08h sub=%0b -> mant=%07h exp=%02h sign=%0b sticky=%0b lat=%0d",
                 a, b, s, obs_mant, obs_exp, obs_sign, obs_sticky, obs_lat);
    endtask

    // Accept the result and return to IDLE.
    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_mantissa !== '0 || bus.out_exponent !== '0 || bus.out_sign !== 1'b0 || bus.out_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: mant=%h exp=%h sign=%b sticky=%b, required all 0",
                     bus.out_mantissa, bus.out_exponent, bus.out_sign, bus.out_sticky);
        end
    endtask

    task automatic test_add_vectors();
        vec_t vecs[9];
        logic exp_sticky;
        vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 25'h1000000, 8'h7F, 1'b0, 2,  1'b0};
        vecs[1] = '{32'h3FC00000, 32'h3F400000, 1'b0, 25'h1200000, 8'h7F, 1'b0, 3,  1'b0};
        vecs[2] = '{32'h40000000, 32'h40000000, 1'b1, 25'h0000000, 8'h80, 1'b0, 2,  1'b0};
        vecs[3] = '{32'h3F800000, 32'hC0800000, 1'b0, 25'h0600000, 8'h81, 1'b1, 4,  1'b0};
        vecs[4] = '{32'h4E800000, 32'h3F800000, 1'b0, 25'h0800000, 8'h9D, 1'b0, 2,  1'b1};
        vecs[5] = '{32'h4B800000, 32'h3F800000, 1'b0, 25'h0800000, 8'h97, 1'b0, 26, 1'b1};
        vecs[6] = '{32'h4C000000, 32'h3F800000, 1'b0, 25'h0800000, 8'h98, 1'b0, 2,  1'b1};
        vecs[7] = '{32'h00000001, 32'h00000001, 1'b0, 25'h0000002, 8'h00, 1'b0, 2,  1'b0};
        vecs[8] = '{32'h3F800000, 32'h3FC00000, 1'b1, 25'h0400000, 8'h7F, 1'b1, 2,  1'b0};
        for (int i = 0; i < 9; i++) begin
`ifdef FPU_ALIGN_STICKY_EN
            exp_sticky = vecs[i].sticky_en;
`else
            exp_sticky = 1'b0;
`endif
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            checks++;
            if (obs_mant !== vecs[i].mant) begin
                errors++;
                $display("FAIL vec%0d_mantissa: got %h, required %h", i, obs_mant, vecs[i].mant);
            end
            checks++;
            if (obs_exp !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d_exponent: got %h, required %h", i, obs_exp, vecs[i].exp);
            end
            checks++;
            if (obs_sign !== vecs[i].sign) begin
                errors++;
                $display("FAIL vec%0d_sign: got %b, required %b", i, obs_sign, vecs[i].sign);
            end
            checks++;
            if (obs_lat != vecs[i].lat) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d, required %0d", i, obs_lat, vecs[i].lat);
            end
            checks++;
            if (obs_sticky !== exp_sticky) begin
                errors++;
                $display("FAIL vec%0d_sticky: got %b, required %b", i, obs_sticky, exp_sticky);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        do_op(32'h3F800000, 32'h3F800000, 1'b0);
        // Offer a new operand while DONE: it must be ignored
        bus.a        = 32'h4E800000;
        bus.b        = 32'h3F800000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_handshake%0d: out_valid=%b in_ready=%b, required 1/0", i, bus.out_valid, bus.in_ready);
            end
            checks++;
            if (bus.out_mantissa !== 25'h1000000 || bus.out_exponent !== 8'h7F) begin
                errors++;
                $display("FAIL bp_hold%0d: mant=%h exp=%h, required 1000000/7f", i, bus.out_mantissa, bus.out_exponent);
            end
        end
        bus.in_valid = 1'b0;
        release_result();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_mantissa !== 25'h1000000) begin
            errors++;
            $display("FAIL bp_idle_hold: in_ready=%b mant=%h, required 1/1000000", bus.in_ready, bus.out_mantissa);
        end
    endtask

    task automatic test_reset_mid_align();
        @(negedge clk);
        bus.a        = 32'h4B800000;
        bus.b        = 32'h3F800000;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL align_busy: in_ready=%b out_valid=%b, required 0/0", bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_mantissa !== '0 || bus.out_exponent !== '0) begin
            errors++;
            $display("FAIL mid_align_reset: out_valid=%b in_ready=%b mant=%h exp=%h, required 0/1/0/0",
                     bus.out_valid, bus.in_ready, bus.out_mantissa, bus.out_exponent);
        end
        $display("reset asserted mid-ALIGN");
        @(negedge clk);
        rst_n = 1'b1;
        // The aborted operation must not leak into the next one
        do_op(32'h3FC00000, 32'h3F400000, 1'b0);
        checks++;
        if (obs_mant !== 25'h1200000 || obs_exp !== 8'h7F || obs_lat != 3) begin
            errors++;
            $display("FAIL post_reset_op: mant=%h exp=%h lat=%0d, required 1200000/7f/3", obs_mant, obs_exp, obs_lat);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        do_op(32'h3F800000, 32'hC0800000, 1'b0);
        checks++;
        if (obs_mant !== 25'h0600000 || obs_sign !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: mant=%h sign=%b, required 0600000/1", obs_mant, obs_sign);
        end
        release_result();
        do_op(32'h40000000, 32'h40000000, 1'b1);
        checks++;
        if (obs_mant !== '0 || obs_sign !== 1'b0 || obs_exp !== 8'h80) begin
            errors++;
            $display("FAIL b2b_second: mant=%h sign=%b exp=%h, required 0/0/80", obs_mant, obs_sign, obs_exp);
        end
        release_result();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add_vectors();
        test_backpressure();
        test_reset_mid_align();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
